// File: rtl/synchronizer_filter_shift_reg.sv
// synchronizer_filter_shift_reg
// Multi-channel synchronizer for slow asynchronous level inputs. Each channel
// passes through a DEPTH-stage flop chain, then a stability filter that only
// lets the filtered level follow the synchronized value after it has disagreed
// for FILTER consecutive cycles. Registered rise/fall pulses and a combined
// changed flag are emitted in the same cycle the filtered level updates.
module synchronizer_filter_shift_reg #(
  parameter int               WIDTH  = 1,
  parameter int               DEPTH  = 3,
  parameter logic [WIDTH-1:0] INIT   = '0,
  parameter int               FILTER = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_d,
  output logic [WIDTH-1:0] io_q,
  output logic [WIDTH-1:0] io_rise,
  output logic [WIDTH-1:0] io_fall,
  output logic             io_changed
);

  // Counter only has to reach FILTER-1, so FILTER=1 and FILTER=2 both fit in
  // a single bit; FILTER=1 leaves it permanently at zero.
  localparam int               CNT_W    = (FILTER > 1) ? $clog2(FILTER) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Synchronizer chain: stage 0 is the only flop that sees io_d directly.
  logic [WIDTH-1:0] syncStage_q [DEPTH];
  logic [WIDTH-1:0] syncLevel;

  // Filter state and the next-state values feeding the output registers.
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] update;
  logic [WIDTH-1:0] level_q;
  logic [WIDTH-1:0] level_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             changed_q;
  logic             changed_d;

  // Plain shift of the raw inputs; no logic between stages so every stage
  // gets a full cycle to resolve metastability.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        syncStage_q[k] <= INIT;
      end
    end else begin
      syncStage_q[0] <= io_d;
      for (int k = 1; k < DEPTH; k++) begin
        syncStage_q[k] <= syncStage_q[k-1];
      end
    end
  end

  assign syncLevel = syncStage_q[DEPTH-1];

  // Per-channel stability counter: any agreement clears it, and the level
  // only flips once the disagreement has persisted through CNT_LAST.
  always_comb begin
    update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (syncLevel[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          update[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Next filtered level and edge pulses, derived from the update strobes so
  // the pulses land in the first cycle the new level is visible.
  always_comb begin
    level_d   = (level_q & ~update) | (syncLevel & update);
    rise_d    = update & syncLevel;
    fall_d    = update & ~syncLevel;
    changed_d = |(rise_d | fall_d);
  end

  // Filter counters; reset discards any partially counted disagreement.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output registers; reset wins over a coincident update so no pulse escapes.
  always_ff @(posedge clock) begin
    if (reset) begin
      level_q   <= INIT;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      level_q   <= level_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign io_q       = level_q;
  assign io_rise    = rise_q;
  assign io_fall    = fall_q;
  assign io_changed = changed_q;

endmodule

// File: tb/tb_synchronizer_filter_shift_reg.sv
// Testbench for synchronizer_filter_shift_reg. Two instances: a 4-channel
// DEPTH=3/FILTER=4 block with a non-zero reset value, and a minimal
// 1-channel DEPTH=2/FILTER=1 block. Outputs are compared #1 after each edge.
module tb_synchronizer_filter_shift_reg;

  localparam int         WA    = 4;
  localparam int         DA    = 3;
  localparam int         FA    = 4;
  localparam logic [3:0] INITA = 4'b1010;
  localparam int         DB    = 2;
  localparam int         FB    = 1;

  logic       clock = 1'b0;
  logic       resetA, resetB;
  logic [3:0] dA, qA, riseA, fallA;
  logic       chA;
  logic [0:0] dB, qB, riseB, fallB;
  logic       chB;

  int vectors = 0;
  int miscompares = 0;

  // Free-running clock shared by both instances.
  always #5 clock = ~clock;

  synchronizer_filter_shift_reg #(
    .WIDTH(WA), .DEPTH(DA), .INIT(INITA), .FILTER(FA)
  ) dutA (
    .clock(clock), .reset(resetA), .io_d(dA), .io_q(qA),
    .io_rise(riseA), .io_fall(fallA), .io_changed(chA)
  );

  synchronizer_filter_shift_reg #(
    .WIDTH(1), .DEPTH(DB), .INIT(1'b0), .FILTER(FB)
  ) dutB (
    .clock(clock), .reset(resetB), .io_d(dB), .io_q(qB),
    .io_rise(riseB), .io_fall(fallB), .io_changed(chB)
  );

  // Reference model A: a delay line of sampled inputs plus, per channel, a
  // count of consecutive disagreeing cycles that must reach FILTER.
  logic [3:0] mHist [DA];
  int         mRun [WA];
  logic [3:0] mQ, mRise, mFall;
  logic       mChg;

  // Reference model B: with FILTER=1 the level is simply the input delayed.
  logic [0:0] bHist [DB];
  logic [0:0] bQ, bRise, bFall;
  logic       bChg;

  task automatic modelStepA(input logic rst, input logic [3:0] d);
    logic [3:0] sync, nr, nf;
    if (rst) begin
      for (int k = 0; k < DA; k++) mHist[k] = INITA;
      for (int i = 0; i < WA; i++) mRun[i] = 0;
      mQ = INITA; mRise = '0; mFall = '0; mChg = 1'b0;
    end else begin
      sync = mHist[DA-1];
      nr = '0; nf = '0;
      for (int i = 0; i < WA; i++) begin
        if (sync[i] != mQ[i]) begin
          mRun[i]++;
          if (mRun[i] >= FA) begin
            mQ[i] = sync[i];
            nr[i] = sync[i];
            nf[i] = !sync[i];
            mRun[i] = 0;
          end
        end else begin
          mRun[i] = 0;
        end
      end
      for (int k = DA-1; k > 0; k--) mHist[k] = mHist[k-1];
      mHist[0] = d;
      mRise = nr; mFall = nf; mChg = |(nr | nf);
    end
  endtask

  task automatic modelStepB(input logic rst, input logic [0:0] d);
    logic [0:0] newQ;
    if (rst) begin
      for (int k = 0; k < DB; k++) bHist[k] = 1'b0;
      bQ = 1'b0; bRise = 1'b0; bFall = 1'b0; bChg = 1'b0;
    end else begin
      newQ  = bHist[DB-1];
      bRise = newQ & ~bQ;
      bFall = ~newQ & bQ;
      bChg  = bRise[0] | bFall[0];
      bQ    = newQ;
      for (int k = DB-1; k > 0; k--) bHist[k] = bHist[k-1];
      bHist[0] = d;
    end
  endtask

  // One clock edge: models advance with the inputs the DUTs just sampled.
  task automatic step();
    @(posedge clock);
    modelStepA(resetA, dA);
    modelStepB(resetB, dB);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] d);
    resetA = rst;
    dA     = d;
    step();
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name);
    checkValue(name, {19'd0, qA, riseA, fallA, chA}, {19'd0, mQ, mRise, mFall, mChg});
  endtask

  task automatic checkOutputB(input string name);
    checkValue(name, {28'd0, qB, riseB, fallB, chB}, {28'd0, bQ, bRise, bFall, bChg});
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       chg;
  } vec_t;

  vec_t tbl[$];

  function automatic void addVec(input logic rst, input logic [3:0] d, input logic [3:0] q,
                                 input logic [3:0] r, input logic [3:0] f, input logic c);
    vec_t v;
    v.rst = rst; v.d = d; v.q = q; v.rise = r; v.fall = f; v.chg = c;
    tbl.push_back(v);
  endfunction

  initial begin
    logic [31:0] rnd;
    logic [3:0]  dHold;
    int          hold;
    int          riseCnt, qHigh, riseIdx, fallIdx, chgCnt, firstIdx;
    logic [3:0]  pulseRise, pulseFall;
    logic        prevRise;

    resetA = 1'b1; dA = 4'b0101;
    resetB = 1'b1; dB = 1'b0;

    // Reset with io_d opposite to INIT, release, then a fall and a rise on bit 0.
    addVec(1, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 0);
    addVec(1, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 6; i++) addVec(0, 4'b0101, 4'b1010, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b0101, 4'b0101, 4'b0101, 4'b1010, 1);
    addVec(0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 6; i++) addVec(0, 4'b0100, 4'b0101, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 1);
    for (int i = 0; i < 6; i++) addVec(0, 4'b0101, 4'b0100, 4'b0000, 4'b0000, 0);
    addVec(0, 4'b0101, 4'b0101, 4'b0001, 4'b0000, 1);
    addVec(0, 4'b0101, 4'b0101, 4'b0000, 4'b0000, 0);

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].d);
      checkValue($sformatf("table[%0d]", i),
                 {19'd0, qA, riseA, fallA, chA},
                 {19'd0, tbl[i].q, tbl[i].rise, tbl[i].fall, tbl[i].chg});
    end
    checkOutputB("resetB");

    // Settle bit 0 low, then a 3-cycle glitch that must be swallowed.
    for (int i = 0; i < 10; i++) begin applyStimulus(0, 4'b0100); checkOutput("settle"); end
    riseCnt = 0; qHigh = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, (i < 3) ? 4'b0101 : 4'b0100);
      checkOutput("glitch3Model");
      riseCnt += int'(riseA[0]);
      qHigh   += int'(qA[0]);
    end
    checkValue("glitch3", riseCnt + qHigh, 0);

    // A 4-cycle pulse is accepted: rise 6 edges after sampling, fall 4 later.
    riseIdx = -1; fallIdx = -1;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(0, (i < 4) ? 4'b0101 : 4'b0100);
      checkOutput("pulse4Model");
      if (riseA[0] && riseIdx < 0) riseIdx = i;
      if (fallA[0] && fallIdx < 0) fallIdx = i;
    end
    checkValue("pulse4Rise", riseIdx, DA + FA - 1);
    checkValue("pulse4Gap", fallIdx - riseIdx, FA);

    // Two channels change in opposite directions on the same edge.
    chgCnt = 0; pulseRise = '0; pulseFall = '0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 4'b0010);
      checkOutput("parallelModel");
      if (chA) begin chgCnt++; pulseRise = riseA; pulseFall = fallA; end
    end
    checkValue("parallelCount", chgCnt, 1);
    checkValue("parallelPulse", {pulseRise, pulseFall}, {4'b0010, 4'b0100});

    // Reset one cycle while bit 0's counter sits at 2.
    for (int i = 0; i < 5; i++) begin applyStimulus(0, 4'b0011); checkOutput("midModel"); end
    applyStimulus(1, 4'b0011);
    checkValue("midReset", {qA, riseA, fallA, 3'b000, chA}, {INITA, 4'b0000, 4'b0000, 4'b0000});
    firstIdx = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 4'b0011);
      checkOutput("midReleaseModel");
      if (chA && firstIdx < 0) begin
        firstIdx = i;
        checkValue("midReleaseQ", qA, 4'b0011);
      end
    end
    checkValue("midReleaseLatency", firstIdx, DA + FA - 1);

    // Randomized held levels with occasional resets against the model.
    hold = 0; dHold = '0;
    for (int s = 0; s < 400; s++) begin
      if (hold == 0) begin
        rnd   = $urandom;
        dHold = rnd[3:0];
        hold  = $urandom_range(1, 7);
      end
      hold--;
      applyStimulus($urandom_range(0, 49) == 0, dHold);
      checkOutput("random");
    end

    // Minimal instance: input toggles every cycle, pulses alternate.
    resetA = 1'b0;
    step(); step();
    resetB = 1'b0;
    prevRise = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dB = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
      checkOutputB("toggleModel");
      if (i >= 2) checkValue("toggleOnePulse", {31'd0, riseB[0] ^ fallB[0]}, 1);
      if (i >= 3) checkValue("toggleAlternate", {31'd0, riseB[0] ^ prevRise}, 1);
      prevRise = riseB[0];
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/synchronizer_filter_shift_reg.md
# synchronizer_filter_shift_reg

Multi-channel input synchronizer with per-channel glitch filter and edge detection. It generalises the single-bit reset-synchronizer shift register to WIDTH independent channels, a configurable chain depth and a configurable reset value. It adds a stability filter and registered rise/fall pulses. It sits at the boundary where slow, asynchronous or bouncy level signals (interrupt lines, straps, debug requests) enter the core clock domain.

## Interface
- WIDTH, 1: number of independent channels (≥1).
- DEPTH, 3: synchronizer flop stages per channel (≥2).
- INIT, 0: WIDTH-bit reset value for every sync stage and for io_q.
- FILTER, 4: cycles the synchronized value must differ stably from io_q before io_q updates (≥1; 1 = no filtering).
- clock  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- io_d  input  WIDTH  asynchronous level inputs.
- io_q  output  WIDTH  filtered, synchronized levels.
- io_rise  output  WIDTH  one-cycle pulse when io_q[i] goes 0→1.
- io_fall  output  WIDTH  one-cycle pulse when io_q[i] goes 1→0.
- io_changed  output  1  OR of all io_rise/io_fall bits in the same cycle.

## Operation
- Sync chain per channel: stage[0] <= io_d[i]; stage[k] <= stage[k-1]; sync[i] = stage[DEPTH-1]. No logic between stages.
- Filter per channel: counter cnt[i], width max(1, clog2(FILTER)).
  - sync[i] == io_q[i]: cnt <= 0; io_q holds.
  - sync[i] != io_q[i] and cnt < FILTER-1: cnt <= cnt+1; io_q holds.
  - sync[i] != io_q[i] and cnt == FILTER-1: io_q[i] <= sync[i]; cnt <= 0.
- A mismatch that disappears before reaching FILTER consecutive cycles clears cnt and leaves no trace. A glitch shorter than FILTER cycles at sync is rejected.
- Edge pulses are registered together with io_q:
  - io_rise[i] <= update & sync[i]
  - io_fall[i] <= update & !sync[i]
  - Each pulse lasts exactly one cycle. It is coincident with the first cycle io_q shows the new value.
- io_changed <= OR over i of the next io_rise/io_fall values (registered, aligned with the pulses).
- Channels are fully independent. Simultaneous changes on several channels each produce their own pulse in the same cycle.

## Timing
- Reset (synchronous, priority over everything):
  - all stages <= INIT; io_q <= INIT; cnt <= 0; io_rise = io_fall = 0; io_changed = 0.
  - Outputs take these values on the first edge with reset high and hold them while reset stays high.
- After reset release, the chain holds INIT, so no spurious pulse is generated. If io_d already differs from INIT, it propagates with full latency.
- Latency: io_d[i] changes and is first sampled at edge n, then held. io_q[i] and its pulse appear after edge n+DEPTH+FILTER-1.
  - DEPTH=3, FILTER=4: edge n+6.
- Minimum accepted pulse width at io_d: FILTER cycles, plus metastability resolution uncertainty of ±1 cycle.
- Reset mid-filter: cnt is discarded, io_q returns to INIT, no pulse is emitted for that edge. Counting restarts from 0 after release.
- Reset asserted in the same cycle a filter update would occur: reset wins, and no pulse is emitted.
- FILTER=1: io_q follows sync with one register of delay. An input toggling every cycle produces alternating rise/fall pulses every cycle.

## Test plan
- Reset: WIDTH=4, INIT=4'b1010, io_d=4'b0101 throughout reset.
  - During reset and on the first cycle after release: io_q=1010, io_rise=io_fall=0.
  - io_q reaches 0101 at release+DEPTH+FILTER-1, with rise on bits 0 and 2 and fall on bits 1 and 3 in the same cycle.
- Latency, DEPTH=3, FILTER=4: io_d[0] 0→1 sampled at edge n.
  - io_q[0]=1 after edge n+6.
  - io_rise[0]=1 and io_changed=1 for exactly that one cycle.
- Glitch rejection:
  - A 3-cycle high pulse on io_d[0] produces no change on io_q and no pulses.
  - A 4-cycle high pulse produces io_rise[0], then io_fall[0] exactly 4 cycles later.
- Parallel channels: io_d[1] 0→1 and io_d[2] 1→0 on the same edge.
  - io_rise[1] and io_fall[2] pulse in the same cycle.
  - io_changed pulses once.
- Reset mid-operation: assert reset for 1 cycle when cnt[0]=2.
  - Next cycle io_q=INIT with no pulse.
  - After release, with io_d still changed, io_q updates after a full DEPTH+FILTER-1 edges.
- Minimum configuration, FILTER=1, DEPTH=2: io_d[0] toggles every cycle.
  - io_q[0] follows with 2 edges of delay.
  - io_rise and io_fall alternate every cycle.
